// File: rtl/gomoku_pkg.sv
// Shared types for the gomoku board: cell encoding, game result codes,
// controller states and the four scan directions.
package gomoku_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        IN_PLAY   = 2'd0,
        BLACK_WIN = 2'd1,
        WHITE_WIN = 2'd2,
        DRAW      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } fsm_t;

    // Row/column step per direction: H, V, diagonal, anti-diagonal
    localparam int DIR_DX [4] = '{0, 1, 1, 1};
    localparam int DIR_DY [4] = '{1, 0, 1, -1};

endpackage

// File: rtl/gomoku_cells.sv
// Board storage with one write port and one combinational read port.
// Out-of-range reads return EMPTY.
module gomoku_cells
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = 15,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [CW-1:0] wx,
    input  logic [CW-1:0] wy,
    input  cell_t         wdata,
    input  logic [CW-1:0] rx,
    input  logic [CW-1:0] ry,
    output cell_t         rdata
);

    cell_t cells [BOARD_N][BOARD_N];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < BOARD_N; i++) begin
                for (int j = 0; j < BOARD_N; j++) begin
                    cells[i][j] <= EMPTY;
                end
            end
        end else if (we) begin
            cells[wx][wy] <= wdata;
        end
    end

    always_comb begin
        rdata = EMPTY;
        if (int'(rx) < BOARD_N && int'(ry) < BOARD_N) begin
            rdata = cells[rx][ry];
        end
    end

endmodule

// File: rtl/gomoku_board.sv
// Gomoku referee: validates moves, stores stones and scans the last move's
// lines one cell per cycle. Optional draw detection under GOMOKU_DRAW_EN.
module gomoku_board
    import gomoku_pkg::*;
#(
    parameter  int BOARD_N = 15,
    parameter  int WIN_LEN = 5,
    localparam int CW      = $clog2(BOARD_N),
    localparam int MCW     = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic [CW-1:0]  x,
    input  logic [CW-1:0]  y,
    output logic           ready,
    output logic           illegal,
    output logic           turn,
    output logic [1:0]     state,
    output logic [MCW-1:0] move_count
);

    localparam int SW = $clog2(WIN_LEN + 1);

    fsm_t           fsm_q, fsm_n;
    state_t         result_q, result_n;
    logic           turn_q, turn_n;
    logic           illegal_q, illegal_n;
    logic [MCW-1:0] count_q, count_n;
    logic [1:0]     dir_q, dir_n;
    logic           neg_q, neg_n;
    logic [SW-1:0]  step_q, step_n;
    logic [SW-1:0]  run_q, run_n;
    logic [CW-1:0]  ox_q, ox_n, oy_q, oy_n;
    cell_t          colour_q, colour_n;

    logic           we;
    cell_t          wdata;
    logic [CW-1:0]  rx, ry;
    cell_t          rdata;
    int             px, py;
    logic           in_bounds, match, legal;

    gomoku_cells #(.BOARD_N(BOARD_N), .CW(CW)) u_cells (
        .clk    (clk),
        .resetn (resetn),
        .we     (we),
        .wx     (x),
        .wy     (y),
        .wdata  (wdata),
        .rx     (rx),
        .ry     (ry),
        .rdata  (rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm_q     <= S_IDLE;
            result_q  <= IN_PLAY;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
            dir_q     <= '0;
            neg_q     <= 1'b0;
            step_q    <= '0;
            run_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            colour_q  <= EMPTY;
        end else begin
            fsm_q     <= fsm_n;
            result_q  <= result_n;
            turn_q    <= turn_n;
            illegal_q <= illegal_n;
            count_q   <= count_n;
            dir_q     <= dir_n;
            neg_q     <= neg_n;
            step_q    <= step_n;
            run_q     <= run_n;
            ox_q      <= ox_n;
            oy_q      <= oy_n;
            colour_q  <= colour_n;
        end
    end

    // Current probe cell: origin plus step times the signed direction
    always_comb begin
        px = int'(ox_q) + (neg_q ? -int'(step_q) : int'(step_q)) * DIR_DX[dir_q];
        py = int'(oy_q) + (neg_q ? -int'(step_q) : int'(step_q)) * DIR_DY[dir_q];
        in_bounds = (px >= 0) && (px < BOARD_N) && (py >= 0) && (py < BOARD_N);
    end

    assign match = in_bounds && (rdata == colour_q);
    assign legal = (int'(x) < BOARD_N) && (int'(y) < BOARD_N) && (rdata == EMPTY);
    assign wdata = turn_q ? WHITE : BLACK;

    always_comb begin
        fsm_n     = fsm_q;
        result_n  = result_q;
        turn_n    = turn_q;
        illegal_n = 1'b0;
        count_n   = count_q;
        dir_n     = dir_q;
        neg_n     = neg_q;
        step_n    = step_q;
        run_n     = run_q;
        ox_n      = ox_q;
        oy_n      = oy_q;
        colour_n  = colour_q;
        we        = 1'b0;
        rx        = x;
        ry        = y;
        case (fsm_q)
            S_IDLE: begin
                if (go) begin
                    if (!legal) begin
                        illegal_n = 1'b1;
                    end else begin
                        we       = 1'b1;
                        count_n  = count_q + 1'b1;
                        ox_n     = x;
                        oy_n     = y;
                        colour_n = wdata;
                        dir_n    = '0;
                        neg_n    = 1'b0;
                        step_n   = SW'(1);
                        run_n    = SW'(1);
                        fsm_n    = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                rx = CW'(px);
                ry = CW'(py);
                if (match) begin
                    if (int'(run_q) + 1 >= WIN_LEN) begin
                        result_n = (colour_q == WHITE) ? WHITE_WIN : BLACK_WIN;
                        fsm_n    = S_OVER;
                    end else begin
                        run_n  = run_q + 1'b1;
                        step_n = step_q + 1'b1;
                    end
                end else if (!neg_q) begin
                    neg_n  = 1'b1;
                    step_n = SW'(1);
                end else if (dir_q != 2'd3) begin
                    dir_n  = dir_q + 2'd1;
                    neg_n  = 1'b0;
                    step_n = SW'(1);
                    run_n  = SW'(1);
                end else begin
`ifdef GOMOKU_DRAW_EN
                    if (int'(count_q) == BOARD_N * BOARD_N) begin
                        result_n = DRAW;
                        fsm_n    = S_OVER;
                    end else begin
                        turn_n = ~turn_q;
                        fsm_n  = S_IDLE;
                    end
`else
                    turn_n = ~turn_q;
                    fsm_n  = S_IDLE;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    assign ready      = (fsm_q == S_IDLE);
    assign illegal    = illegal_q;
    assign turn       = turn_q;
    assign state      = result_q;
    assign move_count = count_q;

endmodule
